// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: the FSM state encoding.
package layer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/layer_sequencer.sv
// Issues layer numbers 0..LAYER_MAX for each accepted sample, waiting for each
// layer's completion before the next one, then reports sample completion.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int LAYER_ADDR_WIDTH = 1,
    parameter int LAYER_MAX        = 0,
    parameter int SAMPLE_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    output logic [LAYER_ADDR_WIDTH-1:0] layer_number,
    output logic                        layer_number_valid,
    input  logic                        layer_number_ready,
    input  logic                        layer_done_valid,
    output logic                        layer_done_ready,
    output logic                        sample_done_valid,
    input  logic                        sample_done_ready,
    output logic                        busy,
    output logic [SAMPLE_CNT_WIDTH-1:0] sample_count
);

    localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER = LAYER_ADDR_WIDTH'(LAYER_MAX);

    state_e                      state_q, state_d;
    logic [LAYER_ADDR_WIDTH-1:0] layer_cnt_q, layer_cnt_d;
    logic [SAMPLE_CNT_WIDTH-1:0] sample_count_q, sample_count_d;

    logic start_ready_q;
    logic layer_number_valid_q;
    logic layer_done_ready_q;
    logic sample_done_valid_q;
    logic busy_q;

    // Each state's ready/valid output is high exactly in that state, so a
    // transfer in a given state reduces to the matching input being high.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d        = state_q;
        layer_cnt_d    = layer_cnt_q;
        sample_count_d = sample_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    layer_cnt_d = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (layer_number_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (layer_done_valid) begin
                    if (layer_cnt_q == LAST_LAYER) begin
                        state_d = ST_DONE;
                    end else begin
                        layer_cnt_d = layer_cnt_q + LAYER_ADDR_WIDTH'(1);
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (sample_done_ready) begin
                    sample_count_d = sample_count_q + SAMPLE_CNT_WIDTH'(1);
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they always match
    // state_q while staying free of any input-to-output path.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q              <= ST_IDLE;
            layer_cnt_q          <= '0;
            sample_count_q       <= '0;
            start_ready_q        <= 1'b1;
            layer_number_valid_q <= 1'b0;
            layer_done_ready_q   <= 1'b0;
            sample_done_valid_q  <= 1'b0;
            busy_q               <= 1'b0;
        end else begin
            state_q              <= state_d;
            layer_cnt_q          <= layer_cnt_d;
            sample_count_q       <= sample_count_d;
            start_ready_q        <= (state_d == ST_IDLE);
            layer_number_valid_q <= (state_d == ST_ISSUE);
            layer_done_ready_q   <= (state_d == ST_WAIT);
            sample_done_valid_q  <= (state_d == ST_DONE);
            busy_q               <= (state_d != ST_IDLE);
        end
    end

    assign start_ready        = start_ready_q;
    assign layer_number       = layer_cnt_q;
    assign layer_number_valid = layer_number_valid_q;
    assign layer_done_ready   = layer_done_ready_q;
    assign sample_done_valid  = sample_done_valid_q;
    assign busy               = busy_q;
    assign sample_count       = sample_count_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a 3-layer instance (A) and a 1-layer instance with a
// 4-bit sample counter (B), both checked against a transaction-counting model.
module tb_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LAYER_MAX=2, 16-bit count
    logic        rst_a = 1'b1, sv_a = 1'b0, lnr_a = 1'b0, ldv_a = 1'b0, sdr_a = 1'b0;
    logic        sr_a, lnv_a, ldr_a, sdv_a, busy_a;
    logic [1:0]  ln_a;
    logic [15:0] cnt_a;

    // Instance B: LAYER_MAX=0, 4-bit count
    logic        rst_b = 1'b1, sv_b = 1'b0, lnr_b = 1'b0, ldv_b = 1'b0, sdr_b = 1'b0;
    logic        sr_b, lnv_b, ldr_b, sdv_b, busy_b;
    logic [0:0]  ln_b;
    logic [3:0]  cnt_b;

    layer_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(2), .SAMPLE_CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .start_valid(sv_a), .start_ready(sr_a),
        .layer_number(ln_a), .layer_number_valid(lnv_a), .layer_number_ready(lnr_a),
        .layer_done_valid(ldv_a), .layer_done_ready(ldr_a),
        .sample_done_valid(sdv_a), .sample_done_ready(sdr_a),
        .busy(busy_a), .sample_count(cnt_a)
    );

    layer_sequencer #(.LAYER_ADDR_WIDTH(1), .LAYER_MAX(0), .SAMPLE_CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .start_valid(sv_b), .start_ready(sr_b),
        .layer_number(ln_b), .layer_number_valid(lnv_b), .layer_number_ready(lnr_b),
        .layer_done_valid(ldv_b), .layer_done_ready(ldr_b),
        .sample_done_valid(sdv_b), .sample_done_ready(sdr_b),
        .busy(busy_b), .sample_count(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Model per instance: inside a sample?, layers issued, layers completed, samples finished.
    bit m_in [2];
    int m_iss[2];
    int m_dn [2];
    int m_cnt[2];

    task automatic model_reset(input int k);
        m_in[k]  = 1'b0;
        m_iss[k] = 0;
        m_dn[k]  = 0;
        m_cnt[k] = 0;
    endtask

    // Called between edges: compare outputs to the model, then apply the
    // transfers that the coming rising edge will perform.
    task automatic model_step(input int k, input int max_l, input int cw,
                              input bit sv, input bit sr, input int ln, input bit lnv,
                              input bit lnr, input bit ldv, input bit ldr, input bit sdv,
                              input bit sdr, input bit busy, input int cnt,
                              output bit t_layer, output bit t_done, output bit t_sdone);
        string p = (k == 0) ? "A" : "B";
        bit e_lnv = m_in[k] && (m_iss[k] == m_dn[k]) && (m_dn[k] <= max_l);
        bit e_ldr = m_in[k] && (m_iss[k] > m_dn[k]);
        bit e_sdv = m_in[k] && (m_dn[k] == max_l + 1);
        bit t_start;
        check({p, ".start_ready"}, int'(sr), int'(!m_in[k]));
        check({p, ".busy"}, int'(busy), int'(m_in[k]));
        check({p, ".layer_number_valid"}, int'(lnv), int'(e_lnv));
        check({p, ".layer_done_ready"}, int'(ldr), int'(e_ldr));
        check({p, ".sample_done_valid"}, int'(sdv), int'(e_sdv));
        if (e_lnv) check({p, ".layer_number"}, ln, m_iss[k]);
        check({p, ".sample_count"}, cnt, m_cnt[k] & ((1 << cw) - 1));
        t_start = !m_in[k] && sv;
        t_layer = e_lnv && lnr;
        t_done  = e_ldr && ldv;
        t_sdone = e_sdv && sdr;
        if (t_start) begin
            m_in[k]  = 1'b1;
            m_iss[k] = 0;
            m_dn[k]  = 0;
        end
        if (t_layer) m_iss[k]++;
        if (t_done)  m_dn[k]++;
        if (t_sdone) begin
            m_in[k] = 1'b0;
            m_cnt[k]++;
        end
    endtask

    int a_issue_log[$];
    int a_done_n = 0, a_sdone_n = 0, b_sdone_n = 0;

    always @(negedge clk) begin
        bit tl, td, ts;
        if (rst_a) model_reset(0);
        else begin
            model_step(0, 2, 16, sv_a, sr_a, int'(ln_a), lnv_a, lnr_a, ldv_a, ldr_a,
                       sdv_a, sdr_a, busy_a, int'(cnt_a), tl, td, ts);
            if (tl) a_issue_log.push_back(int'(ln_a));
            if (td) a_done_n++;
            if (ts) a_sdone_n++;
        end
    end

    always @(negedge clk) begin
        bit tl, td, ts;
        if (rst_b) model_reset(1);
        else begin
            model_step(1, 0, 4, sv_b, sr_b, int'(ln_b), lnv_b, lnr_b, ldv_b, ldr_b,
                       sdv_b, sdr_b, busy_b, int'(cnt_b), tl, td, ts);
            if (ts) b_sdone_n++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    bit b_done = 1'b0;

    // Instance B: single-layer sample, then counter wrap.
    initial begin
        int i;
        tick(3);
        rst_b = 1'b0;
        lnr_b = 1'b1; sdr_b = 1'b1;
        sv_b = 1'b1;
        tick();
        sv_b = 1'b0;
        check("B.l0_valid", int'(lnv_b), 1);
        check("B.l0_number", int'(ln_b), 0);
        tick();
        check("B.l0_wait", int'(ldr_b), 1);
        ldv_b = 1'b1;
        tick();
        ldv_b = 1'b0;
        check("B.l0_sdone", int'(sdv_b), 1);
        check("B.l0_no_reissue", int'(lnv_b), 0);
        tick();
        check("B.l0_count", int'(cnt_b), 1);
        check("B.l0_idle", int'(busy_b), 0);
        sv_b = 1'b1; ldv_b = 1'b1;
        for (i = 0; i < 300 && b_sdone_n < 17; i++) tick();
        sv_b = 1'b0; ldv_b = 1'b0;
        check("B.wrap_reached", int'(b_sdone_n >= 17), 1);
        tick(2);
        check("B.wrap_count", int'(cnt_b), 1);
        b_done = 1'b1;
    end

    // Instance A: directed scenarios, then randomized traffic.
    initial begin
        int lat, i, sd_before, sd_rand;
        tick(3);
        check("A.rst_start_ready", int'(sr_a), 1);
        check("A.rst_lnv", int'(lnv_a), 0);
        check("A.rst_ldr", int'(ldr_a), 0);
        check("A.rst_sdv", int'(sdv_a), 0);
        check("A.rst_busy", int'(busy_a), 0);
        check("A.rst_layer_number", int'(ln_a), 0);
        check("A.rst_count", int'(cnt_a), 0);
        rst_a = 1'b0;
        tick();

        // Full sample, all readys high, layer_done held high from before ISSUE.
        a_issue_log.delete();
        a_done_n = 0;
        lnr_a = 1'b1; sdr_a = 1'b1; ldv_a = 1'b1; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        check("A.t1_first_issue", int'(lnv_a), 1);
        lat = 1;
        while (busy_a && lat < 40) begin
            tick();
            lat++;
        end
        check("A.t1_latency", lat, 8);
        check("A.t1_issue_count", a_issue_log.size(), 3);
        for (int j = 0; j < a_issue_log.size(); j++) check("A.t1_layer_seq", a_issue_log[j], j);
        check("A.t1_done_consumed", a_done_n, 3);
        check("A.t1_count", int'(cnt_a), 1);
        check("A.t1_busy_after", int'(busy_a), 0);

        // Back-pressure on layer 1, with a second start presented meanwhile.
        ldv_a = 1'b0; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        tick();
        lnr_a = 1'b0; ldv_a = 1'b1;
        tick();
        ldv_a = 1'b0; sv_a = 1'b1;
        for (i = 0; i < 5; i++) begin
            check("A.bp_valid", int'(lnv_a), 1);
            check("A.bp_number", int'(ln_a), 1);
            check("A.bp_start_blocked", int'(sr_a), 0);
            tick();
        end
        check("A.bp_still_held", int'(lnv_a), 1);
        lnr_a = 1'b1; ldv_a = 1'b1;
        for (i = 0; i < 40 && !sr_a; i++) tick();
        check("A.bs_idle_reached", int'(sr_a), 1);
        check("A.bs_idle_busy", int'(busy_a), 0);
        check("A.bs_count", int'(cnt_a), 2);
        tick();
        sv_a = 1'b0;
        check("A.bs_second_valid", int'(lnv_a), 1);
        check("A.bs_second_layer0", int'(ln_a), 0);
        for (i = 0; i < 40 && busy_a; i++) tick();
        check("A.bs_second_done", int'(busy_a), 0);
        check("A.bs_count2", int'(cnt_a), 3);

        // Reset while waiting on layer 1.
        ldv_a = 1'b0; sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        tick();
        ldv_a = 1'b1;
        tick();
        ldv_a = 1'b0;
        tick();
        check("A.mr_in_wait", int'(ldr_a), 1);
        check("A.mr_layer1", int'(ln_a), 1);
        sd_before = a_sdone_n;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("A.mr_start_ready", int'(sr_a), 1);
        check("A.mr_lnv", int'(lnv_a), 0);
        check("A.mr_ldr", int'(ldr_a), 0);
        check("A.mr_sdv", int'(sdv_a), 0);
        check("A.mr_busy", int'(busy_a), 0);
        check("A.mr_count", int'(cnt_a), 0);
        check("A.mr_no_sdone", a_sdone_n, sd_before);
        tick();

        // Randomized traffic, occasional reset; the model checks every cycle.
        sd_rand = a_sdone_n;
        for (i = 0; i < 3000; i++) begin
            sv_a  = 1'($urandom_range(0, 1));
            lnr_a = 1'($urandom_range(0, 3) != 0);
            ldv_a = 1'($urandom_range(0, 1));
            sdr_a = 1'($urandom_range(0, 1));
            rst_a = 1'($urandom_range(0, 399) == 0);
            tick();
        end
        rst_a = 1'b0; sv_a = 1'b0; lnr_a = 1'b1; ldv_a = 1'b1; sdr_a = 1'b1;
        for (i = 0; i < 40 && busy_a; i++) tick();
        check("A.rand_drained", int'(busy_a), 0);
        check("A.rand_progress", int'(a_sdone_n > sd_rand + 50), 1);

        for (i = 0; i < 1000 && !b_done; i++) tick();
        check("B.finished", int'(b_done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
